// File: rtl/fake_slave_pipeline_no_burst.sv
// Single-cycle Wishbone pipelined slave backed by a small word memory; no burst handling.
// Define FAKE_SLAVE_STALL_INJECT_EN to raise STALL_O every fourth cycle of an active bus cycle.
module fake_slave_pipeline_no_burst #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int GRANULARITY = 8,
    parameter int MEM_DEPTH   = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              CYC_I,
    input  logic                              STB_I,
    input  logic                              WE_I,
    input  logic [ADDR_WIDTH-1:0]             ADR_I,
    input  logic [DATA_WIDTH-1:0]             DAT_I,
    input  logic [DATA_WIDTH/GRANULARITY-1:0] SEL_I,
    input  logic [2:0]                        CTI_I,
    output logic [DATA_WIDTH-1:0]             DAT_O,
    output logic                              ACK_O,
    output logic                              RTY_O,
    output logic                              ERR_O,
    output logic                              STALL_O,
    output logic                              gnt_wb_o
);
    localparam int LANES = DATA_WIDTH / GRANULARITY;
    localparam int OFFS  = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
    logic                  gnt_q;

    logic [ADDR_WIDTH-1:0] word_adr;
    logic                  in_range;
    logic [IDX_W-1:0]      idx;
    logic                  stall;
    logic                  accept;
    logic                  unused_cti;

    // Cycle type is deliberately ignored: every access is handled as classic.
    assign unused_cti = ^CTI_I;

    assign word_adr = ADR_I >> OFFS;
    assign in_range = word_adr < ADDR_WIDTH'(MEM_DEPTH);
    assign idx      = word_adr[IDX_W-1:0];

`ifdef FAKE_SLAVE_STALL_INJECT_EN
    logic [1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = CYC_I ? stall_cnt_q + 2'd1 : 2'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 2'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall = CYC_I & (stall_cnt_q == 2'd3);
`else
    assign stall = 1'b0;
`endif

    assign accept = CYC_I & STB_I & ~stall;

    always_comb begin
        ack_d  = accept & in_range;
        err_d  = accept & ~in_range;
        rdat_d = '0;
        if (accept && in_range && !WE_I) begin
            rdat_d = mem_q[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            rdat_q <= '0;
            gnt_q  <= 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ack_q  <= ack_d;
            err_q  <= err_d;
            rdat_q <= rdat_d;
            gnt_q  <= 1'b1;
            // Writes commit on acceptance even if the master drops CYC_I before the ACK.
            if (accept && in_range && WE_I) begin
                for (int k = 0; k < LANES; k++) begin
                    if (SEL_I[k]) begin
                        mem_q[idx][k*GRANULARITY +: GRANULARITY] <= DAT_I[k*GRANULARITY +: GRANULARITY];
                    end
                end
            end
        end
    end

    assign ACK_O    = ack_q & CYC_I;
    assign ERR_O    = err_q & CYC_I;
    assign DAT_O    = ACK_O ? rdat_q : '0;
    assign RTY_O    = 1'b0;
    assign STALL_O  = stall;
    assign gnt_wb_o = gnt_q;

endmodule

// File: tb/tb_fake_slave_pipeline_no_burst.sv
// Bench for fake_slave_pipeline_no_burst: directed cases plus random traffic against a word-array model.
module tb_fake_slave_pipeline_no_burst;
    logic        clk = 1'b0;
    logic        rst;
    logic        CYC_I, STB_I, WE_I;
    logic [31:0] ADR_I, DAT_I;
    logic [3:0]  SEL_I;
    logic [2:0]  CTI_I;
    logic [31:0] DAT_O;
    logic        ACK_O, RTY_O, ERR_O, STALL_O, gnt_wb_o;

    fake_slave_pipeline_no_burst dut (
        .clk(clk), .rst(rst), .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I),
        .ADR_I(ADR_I), .DAT_I(DAT_I), .SEL_I(SEL_I), .CTI_I(CTI_I),
        .DAT_O(DAT_O), .ACK_O(ACK_O), .RTY_O(RTY_O), .ERR_O(ERR_O),
        .STALL_O(STALL_O), .gnt_wb_o(gnt_wb_o)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [31:0] mem_m [16];
    logic        p_ack, p_err;
    logic [31:0] p_dat;
    int          gcnt;
    int          run;
    logic [31:0] last_dat;
    logic        last_ack, last_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_stall(input logic cyc);
`ifdef FAKE_SLAVE_STALL_INJECT_EN
        return cyc && (run % 4 == 3);
`else
        return 1'b0;
`endif
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) mem_m[i] = 32'h0;
        p_ack = 1'b0; p_err = 1'b0; p_dat = 32'h0;
        gcnt = 0; run = 0;
    endtask

    // Reset for one edge, optionally with a request on the bus that must be ignored.
    task automatic do_reset(input logic busy);
        rst = 1'b1; CYC_I = busy; STB_I = busy; WE_I = 1'b1;
        ADR_I = 32'h4; DAT_I = 32'hDEADBEEF; SEL_I = 4'hF; CTI_I = 3'b000;
        @(posedge clk); #1;
        clear_model();
        check("rst_ack",   ACK_O,    0);
        check("rst_err",   ERR_O,    0);
        check("rst_rty",   RTY_O,    0);
        check("rst_stall", STALL_O,  0);
        check("rst_dat",   DAT_O,    0);
        check("rst_gnt",   gnt_wb_o, 0);
    endtask

    task automatic step(input logic cyc, input logic stb, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel, input logic [2:0] cti);
        logic st;
        int   idx;
        rst = 1'b0; CYC_I = cyc; STB_I = stb; WE_I = we;
        ADR_I = adr; DAT_I = dat; SEL_I = sel; CTI_I = cti;
        #1;
        st = exp_stall(cyc);
        check("stall", STALL_O,  st);
        check("ack",   ACK_O,    p_ack & cyc);
        check("err",   ERR_O,    p_err & cyc);
        check("dat",   DAT_O,    (p_ack & cyc) ? p_dat : 32'h0);
        check("rty",   RTY_O,    0);
        check("gnt",   gnt_wb_o, gcnt >= 1);
        last_dat = DAT_O; last_ack = ACK_O; last_err = ERR_O;
        p_ack = 1'b0; p_err = 1'b0; p_dat = 32'h0;
        if (cyc && stb && !st) begin
            idx = int'(adr >> 2);
            if (adr < 32'd64) begin
                p_ack = 1'b1;
                if (we) begin
                    for (int k = 0; k < 4; k++)
                        if (sel[k]) mem_m[idx][8*k +: 8] = dat[8*k +: 8];
                end else begin
                    p_dat = mem_m[idx];
                end
            end else begin
                p_err = 1'b1;
            end
        end
        run = cyc ? run + 1 : 0;
        gcnt++;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        step(1'b1, 1'b1, 1'b1, adr, dat, sel, 3'b000);
    endtask

    task automatic rd(input logic [31:0] adr);
        step(1'b1, 1'b1, 1'b0, adr, 32'h0, 4'h0, 3'b000);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
    endtask

    initial begin
        rst = 1'b1; CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
        ADR_I = 32'h0; DAT_I = 32'h0; SEL_I = 4'h0; CTI_I = 3'b000;
        do_reset(1'b0);
        do_reset(1'b0);

        // Grant comes up one cycle after reset release.
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
        check("gnt_up", gnt_wb_o, 1);

        wr(32'h4, 32'hA1B1C1D2, 4'hF);
        check("wr4_ack", last_ack, 0);
        rd(32'h4);
        check("wr4_acked", last_ack, 1);
        idle();
        check("rd4_dat", last_dat, 32'hA1B1C1D2);

        // Request presented while in reset must never be answered.
        rd(32'h4);
        do_reset(1'b1);
        idle();
        check("post_rst_ack", last_ack, 0);
        wr(32'h8, 32'hFFFFFFFF, 4'h3);
        rd(32'h8);
        idle();
        check("rd8_dat", last_dat, 32'h0000FFFF);

        for (int i = 0; i < 4; i++) wr(32'(4 * i), $urandom, 4'hF);
        for (int i = 0; i < 4; i++) rd(32'(4 * i));
        idle();

        rd(32'h40);
        idle();
        check("oor_err", last_err, 1);
        check("oor_ack", last_ack, 0);
        check("oor_dat", last_dat, 0);

        wr(32'h10, 32'h12345678, 4'hF);
        rd(32'h10);
        idle();
        check("raw_dat", last_dat, 32'h12345678);

        // Write acked into a dropped cycle still lands in memory.
        wr(32'h14, 32'hCAFEF00D, 4'h5);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
        rd(32'h14);
        idle();
        check("drop_dat", last_dat, 32'h00FE000D);

        for (int c = 1; c < 8; c++) begin
            step(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 3'(c));
        end

        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
        for (int i = 0; i < 8; i++) rd(32'(4 * (i % 4)));
        idle();

        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 32'h4F));
            step($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 a, $urandom, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fake_slave_pipeline_no_burst.md
FAKE_SLAVE_PIPELINE_NO_BURST -- requirements
Module: fake_slave_pipeline_no_burst

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: bus address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: bus data width.
REQ-003 SHALL have parameter GRANULARITY, default 8: bits per SEL lane.
REQ-004 SHALL have parameter MEM_DEPTH, default 16: words of internal memory, power of two.
REQ-005 SHALL have one clock and a synchronous, active-high reset.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 CYC_I  input  1  Wishbone cycle valid.
REQ-009 STB_I  input  1  Wishbone strobe, one request per cycle.
REQ-010 WE_I  input  1  1 = write, 0 = read.
REQ-011 ADR_I  input  ADDR_WIDTH  byte address.
REQ-012 DAT_I  input  DATA_WIDTH  write data.
REQ-013 SEL_I  input  DATA_WIDTH/GRANULARITY  byte-lane enables.
REQ-014 CTI_I  input  3  cycle type, ignored for addressing.
REQ-015 DAT_O  output  DATA_WIDTH  read data.
REQ-016 ACK_O  output  1  normal termination.
REQ-017 RTY_O  output  1  retry termination, constant 0.
REQ-018 ERR_O  output  1  error termination.
REQ-019 STALL_O  output  1  pipeline stall.
REQ-020 gnt_wb_o  output  1  emulated single-master bus grant.

Function
REQ-021 Accept a request in a cycle when CYC_I & STB_I & !STALL_O.
- Accept-cycle fields: WE_I, ADR_I, DAT_I, SEL_I.
REQ-022 Word index = ADR_I >> log2(DATA_WIDTH/8).
- Index >= MEM_DEPTH is out of range.
REQ-023 Accepted in-range write at cycle N: at edge N+1, lanes with SEL_I[k]=1 are updated in mem[index]; other lanes are unchanged.
REQ-024 Accepted in-range read at cycle N: DAT_O = mem[index] and ACK_O=1 during cycle N+1 only.
- Single-cycle latency; no burst optimisation.
- CTI_I=001/010/111 is treated exactly as classic.
REQ-025 Accepted in-range write: ACK_O=1 during cycle N+1.
REQ-026 Out-of-range request: ERR_O=1 (ACK_O=0) during cycle N+1.
- No memory change.
- DAT_O=0.
REQ-027 Back-to-back accepted requests SHALL produce back-to-back responses, one per cycle, in order.
- A read at N+1 of a word written at N SHALL return the new data.
REQ-028 DAT_O SHALL be 0 whenever ACK_O=0.
REQ-029 ACK_O and ERR_O SHALL be gated with CYC_I.
- If CYC_I=0 in the response cycle, the response is dropped.
- An already accepted write is still committed.
REQ-030 ACK_O and ERR_O SHALL be mutually exclusive.
- RTY_O SHALL always be 0.
REQ-031 Without the stall feature, STALL_O SHALL be constant 0.
REQ-032 gnt_wb_o SHALL be 0 during reset and the first cycle after it, then 1 permanently.
- Grant latency = 1 cycle after rst deasserts.

Reset
REQ-033 When rst=1 at a clock edge, after that edge:
- ACK_O=0, ERR_O=0, RTY_O=0, STALL_O=0, DAT_O=0, gnt_wb_o=0.
- Every memory word = 0.
- Pending responses discarded.
- Stall counter = 0.
REQ-034 Reset asserted mid-transaction SHALL cancel any pending response; no ACK/ERR follows.

Configuration
REQ-035 With FAKE_SLAVE_STALL_INJECT_EN defined:
- A 2-bit counter increments every cycle CYC_I=1 and clears when CYC_I=0.
- STALL_O=1 when counter==3 and CYC_I=1.
- Stalled requests are not accepted; the master must hold them.
REQ-036 Without FAKE_SLAVE_STALL_INJECT_EN, no counter is built and REQ-031 applies.

Verification
REQ-037 Reset release -> gnt_wb_o 0 for one cycle, then 1; all other outputs 0.
REQ-038 Write ADR=0x4, DAT=0xA1B1C1D2, SEL=0xF, then read ADR=0x4 -> ACK at N+1 each; read DAT_O=0xA1B1C1D2.
REQ-039 Write ADR=0x8, DAT=0xFFFFFFFF, SEL=0x3 after reset -> read returns 0x0000FFFF.
REQ-040 Four pipelined writes to 0x0/0x4/0x8/0xC in consecutive cycles -> four consecutive ACK cycles; readback of each word matches.
REQ-041 Read ADR=0x40 (index 16, MEM_DEPTH=16) -> ERR_O=1, ACK_O=0, DAT_O=0 in next cycle.
REQ-042 With FAKE_SLAVE_STALL_INJECT_EN, CYC_I held high 8 cycles -> STALL_O high in the 4th and 8th cycles; requests in those cycles receive no response until re-presented.
